// File: rtl/ovc_avail_tracker_if.sv
// Output-VC availability tracker bus: allocator grants, sent-flit events and
// credit returns going in, per-VC availability/occupancy status coming out.
interface ovc_avail_tracker_if #(
  parameter int V = 4,
  parameter int B = 4
);
  localparam int Bw = $clog2(B + 1);

  logic            ovc_alloc_en;
  logic [V-1:0]    ovc_alloc_vc;
  logic            flit_sent_en;
  logic [V-1:0]    flit_sent_vc;
  logic            flit_is_tail;
  logic [V-1:0]    credit_in;
  logic [V-1:0]    ovc_avail;
  logic [V-1:0]    ovc_full;
  logic [V-1:0]    ovc_nearly_full;
  logic [V*Bw-1:0] credit_cnt;
  logic [2:0]      err_flags;

  // Event source side (router control / testbench)
  modport master (
    output ovc_alloc_en, ovc_alloc_vc, flit_sent_en, flit_sent_vc,
           flit_is_tail, credit_in,
    input  ovc_avail, ovc_full, ovc_nearly_full, credit_cnt, err_flags
  );

  // Tracker side
  modport slave (
    input  ovc_alloc_en, ovc_alloc_vc, flit_sent_en, flit_sent_vc,
           flit_is_tail, credit_in,
    output ovc_avail, ovc_full, ovc_nearly_full, credit_cnt, err_flags
  );
endinterface

// File: rtl/ovc_avail_tracker.sv
// Per-output-VC credit counter and FREE/BUSY/DRAIN tracker for one router port.
// A VC is offered for allocation only when it is FREE and holds all B credits.
// Optional macro OVC_CREDIT_ERR_CHK_EN enables sticky credit overflow,
// credit underflow and illegal-allocation flags; otherwise err_flags is 0.
module ovc_avail_tracker #(
  parameter int V = 4,
  parameter int B = 4
) (
  input logic             clk,
  input logic             reset,
  ovc_avail_tracker_if.slave bus
);

  localparam int Bw = $clog2(B + 1);
  localparam logic [Bw-1:0] CNT_MAX = Bw'(B);
  localparam logic [Bw-1:0] CNT_ONE = Bw'(1);

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } vc_state_t;

  logic [V-1:0] send;
  logic [V-1:0] alloc;
  logic [V-1:0] avail;

  assign send  = bus.flit_sent_en ? bus.flit_sent_vc : '0;
  assign alloc = bus.ovc_alloc_en ? bus.ovc_alloc_vc : '0;

  assign bus.ovc_avail = avail;

  for (genvar v = 0; v < V; v++) begin : g_vc
    vc_state_t     state_q;
    vc_state_t     state_d;
    logic [Bw-1:0] cnt_q;
    logic [Bw-1:0] cnt_d;

    // Credit count: send consumes, return refunds, both together cancel; clamp at 0 and B
    always_comb begin
      cnt_d = cnt_q;
      if (send[v] && !bus.credit_in[v]) begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
      end else if (bus.credit_in[v] && !send[v]) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
      end
    end

    // VC lifecycle: grant claims a fully credited free VC, tail starts the drain,
    // and the VC is released once the registered count shows every credit back
    always_comb begin
      state_d = state_q;
      case (state_q)
        FREE:    if (alloc[v] && avail[v]) state_d = BUSY;
        BUSY:    if (send[v] && bus.flit_is_tail) state_d = DRAIN;
        DRAIN:   if (cnt_q == CNT_MAX) state_d = FREE;
        default: state_d = FREE;
      endcase
    end

    // State and counter registers; reset leaves every VC free with full credit
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= FREE;
        cnt_q   <= CNT_MAX;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign avail[v]                  = (state_q == FREE) && (cnt_q == CNT_MAX);
    assign bus.ovc_full[v]           = (cnt_q == '0);
    assign bus.ovc_nearly_full[v]    = (cnt_q <= CNT_ONE);
    assign bus.credit_cnt[v*Bw +: Bw] = cnt_q;
  end

`ifdef OVC_CREDIT_ERR_CHK_EN
  logic [V-1:0] overflow;
  logic [V-1:0] underflow;
  logic [2:0]   err_q;

  for (genvar v = 0; v < V; v++) begin : g_err
    assign overflow[v]  = bus.credit_in[v] && !send[v] && (g_vc[v].cnt_q == CNT_MAX);
    assign underflow[v] = send[v] && !bus.credit_in[v] && (g_vc[v].cnt_q == '0);
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= '0;
    end else begin
      err_q <= err_q | {|(alloc & ~avail), |underflow, |overflow};
    end
  end

  assign bus.err_flags = err_q;
`else
  assign bus.err_flags = '0;
`endif

endmodule

// File: tb/tb_ovc_avail_tracker.sv
// Directed bench for ovc_avail_tracker (V=4, B=4). Each stimulus cycle pushes
// its hand-computed post-edge expectation into a scoreboard queue; a monitor
// pops and compares one entry after every rising edge.
module tb_ovc_avail_tracker;

  localparam int V  = 4;
  localparam int B  = 4;
  localparam int Bw = 3;

`ifdef OVC_CREDIT_ERR_CHK_EN
  localparam logic [2:0] ERR_MASK = 3'b111;
`else
  localparam logic [2:0] ERR_MASK = 3'b000;
`endif

  typedef struct {
    string         name;
    logic [V-1:0]  avail;
    logic [V*Bw-1:0] cnt;
    logic [2:0]    err;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb[$];

  ovc_avail_tracker_if #(.V(V), .B(B)) bus ();

  ovc_avail_tracker #(.V(V), .B(B)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [V*Bw-1:0] cnts(input int c3, input int c2, input int c1, input int c0);
    return {c3[2:0], c2[2:0], c1[2:0], c0[2:0]};
  endfunction

  task automatic checkOutput(input exp_t e);
    logic [V-1:0] exp_full;
    logic [V-1:0] exp_nearly;
    logic [Bw-1:0] c;
    for (int v = 0; v < V; v++) begin
      c = e.cnt[v*Bw +: Bw];
      exp_full[v]   = (c == 3'd0);
      exp_nearly[v] = (c <= 3'd1);
    end
    checks += 5;
    if (bus.credit_cnt !== e.cnt) begin
      errors++;
      $display("[TB] FAIL %s credit_cnt: got %h want %h", e.name, bus.credit_cnt, e.cnt);
    end
    if (bus.ovc_avail !== e.avail) begin
      errors++;
      $display("[TB] FAIL %s ovc_avail: got %b want %b", e.name, bus.ovc_avail, e.avail);
    end
    if (bus.ovc_full !== exp_full) begin
      errors++;
      $display("[TB] FAIL %s ovc_full: got %b want %b", e.name, bus.ovc_full, exp_full);
    end
    if (bus.ovc_nearly_full !== exp_nearly) begin
      errors++;
      $display("[TB] FAIL %s ovc_nearly_full: got %b want %b", e.name, bus.ovc_nearly_full, exp_nearly);
    end
    if (bus.err_flags !== (e.err & ERR_MASK)) begin
      errors++;
      $display("[TB] FAIL %s err_flags: got %b want %b", e.name, bus.err_flags, e.err & ERR_MASK);
    end
  endtask

  // Drive one cycle of inputs on the falling edge and queue the state expected after the next rising edge
  task automatic applyStimulus(input string name, input logic rst,
                               input logic ae, input logic [V-1:0] av,
                               input logic se, input logic [V-1:0] sv, input logic tail,
                               input logic [V-1:0] cr,
                               input logic [V-1:0] exp_avail, input logic [V*Bw-1:0] exp_cnt,
                               input logic [2:0] exp_err);
    exp_t e;
    @(negedge clk);
    reset            = rst;
    bus.ovc_alloc_en = ae;
    bus.ovc_alloc_vc = av;
    bus.flit_sent_en = se;
    bus.flit_sent_vc = sv;
    bus.flit_is_tail = tail;
    bus.credit_in    = cr;
    e.name  = name;
    e.avail = exp_avail;
    e.cnt   = exp_cnt;
    e.err   = exp_err;
    sb.push_back(e);
  endtask

  // Monitor: compare one queued expectation shortly after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    exp_t imm;
    int   budget;
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bus.ovc_alloc_en = 1'b0;
    bus.ovc_alloc_vc = '0;
    bus.flit_sent_en = 1'b0;
    bus.flit_sent_vc = '0;
    bus.flit_is_tail = 1'b0;
    bus.credit_in    = '0;

    //            name          rst ae av       se sv       tl cr       avail    counts            err
    applyStimulus("rst_hold0",  0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b1111, cnts(4,4,4,4), 3'b000);
    applyStimulus("rst_hold1",  0, 0, 4'b0000, 1, 4'b0100, 0, 4'b0000, 4'b1111, cnts(4,4,4,4), 3'b000);
    applyStimulus("idle",       1, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b1111, cnts(4,4,4,4), 3'b000);
    // VC1 packet: grant, three flits with tail, three credits, release one cycle later
    applyStimulus("alloc_vc1",  1, 1, 4'b0010, 0, 4'b0000, 0, 4'b0000, 4'b1101, cnts(4,4,4,4), 3'b000);
    applyStimulus("vc1_send1",  1, 0, 4'b0000, 1, 4'b0010, 0, 4'b0000, 4'b1101, cnts(4,4,3,4), 3'b000);
    applyStimulus("vc1_send2",  1, 0, 4'b0000, 1, 4'b0010, 0, 4'b0000, 4'b1101, cnts(4,4,2,4), 3'b000);
    applyStimulus("vc1_tail",   1, 0, 4'b0000, 1, 4'b0010, 1, 4'b0000, 4'b1101, cnts(4,4,1,4), 3'b000);
    applyStimulus("vc1_cred1",  1, 0, 4'b0000, 0, 4'b0000, 0, 4'b0010, 4'b1101, cnts(4,4,2,4), 3'b000);
    applyStimulus("vc1_cred2",  1, 0, 4'b0000, 0, 4'b0000, 0, 4'b0010, 4'b1101, cnts(4,4,3,4), 3'b000);
    applyStimulus("vc1_cred3",  1, 0, 4'b0000, 0, 4'b0000, 0, 4'b0010, 4'b1101, cnts(4,4,4,4), 3'b000);
    applyStimulus("vc1_free",   1, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b1111, cnts(4,4,4,4), 3'b000);
    // VC2 drained to empty without credits, then one send too many
    applyStimulus("vc2_send1",  1, 0, 4'b0000, 1, 4'b0100, 0, 4'b0000, 4'b1011, cnts(4,3,4,4), 3'b000);
    applyStimulus("vc2_send2",  1, 0, 4'b0000, 1, 4'b0100, 0, 4'b0000, 4'b1011, cnts(4,2,4,4), 3'b000);
    applyStimulus("vc2_send3",  1, 0, 4'b0000, 1, 4'b0100, 0, 4'b0000, 4'b1011, cnts(4,1,4,4), 3'b000);
    applyStimulus("vc2_send4",  1, 0, 4'b0000, 1, 4'b0100, 0, 4'b0000, 4'b1011, cnts(4,0,4,4), 3'b000);
    applyStimulus("vc2_under",  1, 0, 4'b0000, 1, 4'b0100, 1, 4'b0000, 4'b1011, cnts(4,0,4,4), 3'b010);
    applyStimulus("vc2_cred1",  1, 0, 4'b0000, 0, 4'b0000, 0, 4'b0100, 4'b1011, cnts(4,1,4,4), 3'b010);
    applyStimulus("vc2_cred2",  1, 0, 4'b0000, 0, 4'b0000, 0, 4'b0100, 4'b1011, cnts(4,2,4,4), 3'b010);
    applyStimulus("vc2_cred3",  1, 0, 4'b0000, 0, 4'b0000, 0, 4'b0100, 4'b1011, cnts(4,3,4,4), 3'b010);
    applyStimulus("vc2_cred4",  1, 0, 4'b0000, 0, 4'b0000, 0, 4'b0100, 4'b1111, cnts(4,4,4,4), 3'b010);
    // VC0 to count 2, simultaneous send and credit, refill, then all-VC overflow attempt
    applyStimulus("vc0_send1",  1, 0, 4'b0000, 1, 4'b0001, 0, 4'b0000, 4'b1110, cnts(4,4,4,3), 3'b010);
    applyStimulus("vc0_send2",  1, 0, 4'b0000, 1, 4'b0001, 0, 4'b0000, 4'b1110, cnts(4,4,4,2), 3'b010);
    applyStimulus("vc0_both",   1, 0, 4'b0000, 1, 4'b0001, 0, 4'b0001, 4'b1110, cnts(4,4,4,2), 3'b010);
    applyStimulus("vc0_cred1",  1, 0, 4'b0000, 0, 4'b0000, 0, 4'b0001, 4'b1110, cnts(4,4,4,3), 3'b010);
    applyStimulus("vc0_cred2",  1, 0, 4'b0000, 0, 4'b0000, 0, 4'b0001, 4'b1111, cnts(4,4,4,4), 3'b010);
    applyStimulus("cred_over",  1, 0, 4'b0000, 0, 4'b0000, 0, 4'b1111, 4'b1111, cnts(4,4,4,4), 3'b011);
    // VC3 granted, granted again while BUSY, concurrent VC0 grant with VC3 traffic
    applyStimulus("alloc_vc3",  1, 1, 4'b1000, 0, 4'b0000, 0, 4'b0000, 4'b0111, cnts(4,4,4,4), 3'b011);
    applyStimulus("vc3_again",  1, 1, 4'b1000, 0, 4'b0000, 0, 4'b0000, 4'b0111, cnts(4,4,4,4), 3'b111);
    applyStimulus("vc3s_vc0a",  1, 1, 4'b0001, 1, 4'b1000, 0, 4'b0000, 4'b0110, cnts(3,4,4,4), 3'b111);
    applyStimulus("vc3_tail",   1, 0, 4'b0000, 1, 4'b1000, 1, 4'b0000, 4'b0110, cnts(2,4,4,4), 3'b111);
    // Reset mid-packet: checked right away without any clock edge, then held over an edge
    applyStimulus("rst_mid",    0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b1111, cnts(4,4,4,4), 3'b000);
    #1;
    imm.name  = "rst_async";
    imm.avail = 4'b1111;
    imm.cnt   = cnts(4,4,4,4);
    imm.err   = 3'b000;
    checkOutput(imm);
    applyStimulus("rst_rel",    1, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b1111, cnts(4,4,4,4), 3'b000);
    // Tail whose resulting count is B: DRAIN first, FREE on the following cycle
    applyStimulus("alloc_vc2",  1, 1, 4'b0100, 0, 4'b0000, 0, 4'b0000, 4'b1011, cnts(4,4,4,4), 3'b000);
    applyStimulus("vc2_tailB",  1, 0, 4'b0000, 1, 4'b0100, 1, 4'b0100, 4'b1011, cnts(4,4,4,4), 3'b000);
    applyStimulus("vc2_freeB",  1, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b1111, cnts(4,4,4,4), 3'b000);
    applyStimulus("alloc_off",  1, 0, 4'b0001, 0, 4'b0000, 0, 4'b0000, 4'b1111, cnts(4,4,4,4), 3'b000);

    budget = 0;
    while (sb.size() > 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (sb.size() > 0) begin
      errors++;
      checks++;
      $display("[TB] FAIL drain: %0d entries left, want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
